// File: rtl/eq_gain_sequencer.sv
// eq_gain_sequencer
// Sequences band gain codes from a shadow bank into the cascaded graphic
// equalizer cores. A load holds off audio input, streams the bank with a
// gainwe burst and then issues one gainset strobe.
//
// Optional feature macro: EQ_GAIN_RAMP_EN
//   Defined   : every pass moves each applied band at most one code toward the
//               target. Passes are separated by RAMP_GAP cycles of released data.
//   Undefined : one pass writes the target bank directly.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   band_wr           write band_gain into shadow[band_sel]
//   band_sel          band index
//   band_gain         requested gain code
//   commit            request a load of the shadow bank
//   datain_valid      upstream audio sample valid
//   in_valid_gated    datain_valid masked by data_hold
//   data_hold         input gated while high (registered)
//   gainwe            gain write enable to equalizer cores
//   gainset           one-cycle gain apply strobe
//   gain, band_idx    code and band index presented during the burst
//   busy              sequencer not idle
//   cfg_err           one-cycle pulse after an illegal write
//   allgain           applied bank, band0 in the LSBs
//
// state     | meaning
// IDLE      | waiting for commit or pending request
// SETTLE    | data held off, draining DRAIN_CYCLES
// LOAD      | gainwe burst, one band per cycle
// SET       | single gainset strobe, applied bank updated
// RAMP_WAIT | data released between ramp passes (ramp build only)

module eq_gain_sequencer #(
  parameter int NUM_BANDS    = 10,
  parameter int GAIN_W       = 8,
  parameter int GAIN_MAX     = 16,
  parameter int GAIN_DEFAULT = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int RAMP_GAP     = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        band_wr,
  input  logic [3:0]                  band_sel,
  input  logic [GAIN_W-1:0]           band_gain,
  input  logic                        commit,
  input  logic                        datain_valid,
  output logic                        in_valid_gated,
  output logic                        data_hold,
  output logic                        gainwe,
  output logic                        gainset,
  output logic [GAIN_W-1:0]           gain,
  output logic [3:0]                  band_idx,
  output logic                        busy,
  output logic                        cfg_err,
  output logic [NUM_BANDS*GAIN_W-1:0] allgain
);

  localparam int                CNT_W    = $clog2(DRAIN_CYCLES + RAMP_GAP + 1);
  localparam logic [3:0]        NB4      = 4'(NUM_BANDS);
  localparam logic [3:0]        LAST_IDX = 4'(NUM_BANDS - 1);
  localparam logic [GAIN_W-1:0] GMAX     = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] GDEF     = GAIN_W'(GAIN_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LOAD,
    SET
`ifdef EQ_GAIN_RAMP_EN
    , RAMP_WAIT
`endif
  } state_t;

  state_t             state, state_nxt;
  logic               pending;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         idx;
  logic [GAIN_W-1:0]  shadow     [NUM_BANDS];
  logic [GAIN_W-1:0]  shadow_nxt [NUM_BANDS];
  logic [GAIN_W-1:0]  snap       [NUM_BANDS];
  logic [GAIN_W-1:0]  applied    [NUM_BANDS];
  logic [GAIN_W-1:0]  load_val   [NUM_BANDS];
  logic               sel_ok;
  logic [GAIN_W-1:0]  wr_val;
  logic               snap_take;
  logic               ramp_done;

  assign sel_ok = band_sel < NB4;
  assign wr_val = (band_gain > GMAX) ? GMAX : band_gain;

  // Shadow bank including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    shadow_nxt = shadow;
    if (band_wr && sel_ok) shadow_nxt[band_sel] = wr_val;
  end

  // Values presented in the current pass and written to the applied bank.
  always_comb begin
    ramp_done = 1'b1;
    for (int i = 0; i < NUM_BANDS; i++) begin
`ifdef EQ_GAIN_RAMP_EN
      if (applied[i] < snap[i])      load_val[i] = applied[i] + GAIN_W'(1);
      else if (applied[i] > snap[i]) load_val[i] = applied[i] - GAIN_W'(1);
      else                           load_val[i] = applied[i];
`else
      load_val[i] = snap[i];
`endif
      if (load_val[i] != snap[i]) ramp_done = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (commit || pending) state_nxt = SETTLE;
      SETTLE: if (cnt == '0) state_nxt = LOAD;
      LOAD:   if (idx == LAST_IDX) state_nxt = SET;
      SET: begin
`ifdef EQ_GAIN_RAMP_EN
        state_nxt = ramp_done ? IDLE : RAMP_WAIT;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef EQ_GAIN_RAMP_EN
      RAMP_WAIT: if (cnt == '0) state_nxt = SETTLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign snap_take = (state == IDLE) && (state_nxt == SETTLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b1;
      data_hold <= 1'b0;
      cfg_err   <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow[i]  <= GDEF;
        snap[i]    <= GDEF;
        applied[i] <= GDEF;
      end
    end else begin
      state     <= state_nxt;
      data_hold <= (state_nxt == SETTLE) || (state_nxt == LOAD) || (state_nxt == SET);
      cfg_err   <= band_wr && (!sel_ok || (band_gain > GMAX));
      shadow    <= shadow_nxt;

      if (snap_take) begin
        snap    <= shadow_nxt;
        pending <= 1'b0;
      end else if (commit) begin
`ifdef EQ_GAIN_RAMP_EN
        // Retarget the ramp in place; the gap count keeps running.
        if (state == RAMP_WAIT) snap <= shadow_nxt;
        else                    pending <= 1'b1;
`else
        pending <= 1'b1;
`endif
      end

      if (state == SET) applied <= load_val;

      if ((state_nxt == SETTLE) && (state != SETTLE))
        cnt <= CNT_W'(DRAIN_CYCLES - 1);
`ifdef EQ_GAIN_RAMP_EN
      else if ((state_nxt == RAMP_WAIT) && (state != RAMP_WAIT))
        cnt <= CNT_W'(RAMP_GAP - 1);
`endif
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);

      if (state == LOAD) idx <= idx + 4'd1;
      else               idx <= '0;
    end
  end

  assign gainwe         = (state == LOAD);
  assign gainset        = (state == SET);
  assign gain           = gainwe ? load_val[idx] : '0;
  assign band_idx       = gainwe ? idx : '0;
  assign busy           = (state != IDLE);
  assign in_valid_gated = datain_valid & ~data_hold;

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_allgain
    assign allgain[g*GAIN_W +: GAIN_W] = applied[g];
  end

endmodule
